// File: rtl/udp_tx_stream_arbiter_pkg.sv
// udp_tx_arb_pkg: shared types for the UDP Tx stream arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> META -> DATA -> IDLE)
//   ch_w()      : channel-index width for a given channel count
//   udp_meta_t  : UDP Tx meta bundle, field order as seen by the core wrapper
package udp_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [15:0] data_len;
    logic [31:0] ip_addr;
    logic [15:0] dst_port;
    logic [15:0] src_port;
  } udp_meta_t;

endpackage

// File: rtl/udp_tx_stream_arbiter_if.sv
// udp_tx_stream_arbiter_if: N lanes of UDP Tx meta + data stream, flattened
// per lane (lane i at [i*W +: W]).
//   master modport : stream source (drives valid/payload, takes ready)
//   slave modport  : stream sink   (takes valid/payload, drives ready)
interface udp_tx_stream_arbiter_if #(
  parameter int N              = 1,
  parameter int DATA_WIDTH     = 256,
  parameter int KEEP_WIDTH     = 32,
  parameter int IP_ADDR_WIDTH  = 32,
  parameter int UDP_PORT_WIDTH = 16,
  parameter int UDP_LEN_WIDTH  = 16
);

  logic [N-1:0]                udp_meta_valid;
  logic [N-1:0]                udp_meta_ready;
  logic [N*IP_ADDR_WIDTH-1:0]  udp_meta_ip_addr;
  logic [N*UDP_PORT_WIDTH-1:0] udp_meta_dst_port;
  logic [N*UDP_PORT_WIDTH-1:0] udp_meta_src_port;
  logic [N*UDP_LEN_WIDTH-1:0]  udp_meta_data_len;

  logic [N-1:0]                data_stream_tvalid;
  logic [N-1:0]                data_stream_tready;
  logic [N*DATA_WIDTH-1:0]     data_stream_tdata;
  logic [N*KEEP_WIDTH-1:0]     data_stream_tkeep;
  logic [N-1:0]                data_stream_tfirst;
  logic [N-1:0]                data_stream_tlast;

  modport master (
    output udp_meta_valid, udp_meta_ip_addr, udp_meta_dst_port,
           udp_meta_src_port, udp_meta_data_len,
    input  udp_meta_ready,
    output data_stream_tvalid, data_stream_tdata, data_stream_tkeep,
           data_stream_tfirst, data_stream_tlast,
    input  data_stream_tready
  );

  modport slave (
    input  udp_meta_valid, udp_meta_ip_addr, udp_meta_dst_port,
           udp_meta_src_port, udp_meta_data_len,
    output udp_meta_ready,
    input  data_stream_tvalid, data_stream_tdata, data_stream_tkeep,
           data_stream_tfirst, data_stream_tlast,
    output data_stream_tready
  );

endinterface

// File: rtl/udp_tx_stream_arbiter_rr_picker.sv
// udp_rr_picker: combinational round-robin search.
//   req    : request vector
//   rr_ptr : last served channel; search starts at rr_ptr+1 (mod NUM_CH)
//   found  : any request present
//   idx    : first requesting channel in search order
module udp_rr_picker
  import udp_tx_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  int unsigned c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      c = (32'(rr_ptr) + i) % NUM_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/udp_tx_stream_arbiter.sv
// udp_tx_stream_arbiter: packet-atomic round-robin sharing of the core's
// single UDP Tx input (meta + data stream) between NUM_CH requesters.
//   clk, reset_n : clock, asynchronous active-low reset
//   s            : NUM_CH requester lanes (slave side)
//   m            : single lane towards the core (master side)
//   grant_valid  : a channel owns the core (META or DATA)
//   grant_id     : owning channel
//   len_err      : one-cycle pulse after tlast when summed tkeep bytes differ
//                  from the packet's data_len; only with UDP_TX_ARB_LEN_CHECK_EN
//                  defined, otherwise tied 0
module udp_tx_stream_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int DATA_WIDTH     = 256,
  parameter  int KEEP_WIDTH     = 32,
  parameter  int IP_ADDR_WIDTH  = 32,
  parameter  int UDP_PORT_WIDTH = 16,
  parameter  int UDP_LEN_WIDTH  = 16,
  localparam int CH_W           = ch_w(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  udp_tx_stream_arbiter_if.slave  s,
  udp_tx_stream_arbiter_if.master m,
  output logic                   grant_valid,
  output logic [CH_W-1:0]        grant_id,
  output logic                   len_err
);

  localparam logic [1:0]      ST_IDLE  = IDLE;
  localparam logic [1:0]      ST_META  = META;
  localparam logic [1:0]      ST_DATA  = DATA;
  localparam logic [CH_W-1:0] RR_RESET = CH_W'(NUM_CH - 1);

  logic [1:0]      state;
  logic [CH_W-1:0] rr_ptr;
  logic            pick_found;
  logic [CH_W-1:0] pick_idx;
  logic            meta_hs;
  logic            data_hs;

  udp_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req    (s.udp_meta_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign meta_hs     = m.udp_meta_valid[0] & m.udp_meta_ready[0];
  assign data_hs     = m.data_stream_tvalid[0] & m.data_stream_tready[0];
  assign grant_valid = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= RR_RESET;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_found) begin
          grant_id <= pick_idx;
          state    <= ST_META;
        end
        ST_META: if (meta_hs) begin
          state  <= ST_DATA;
          rr_ptr <= grant_id;
        end
        ST_DATA: if (data_hs && m.data_stream_tlast[0]) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Payload follows grant_id at all times; only valid/ready are state-gated,
  // so meta and data can never be presented together.
  always_comb begin
    m.udp_meta_valid     = '0;
    m.udp_meta_ip_addr   = '0;
    m.udp_meta_dst_port  = '0;
    m.udp_meta_src_port  = '0;
    m.udp_meta_data_len  = '0;
    m.data_stream_tvalid = '0;
    m.data_stream_tdata  = '0;
    m.data_stream_tkeep  = '0;
    m.data_stream_tfirst = '0;
    m.data_stream_tlast  = '0;
    s.udp_meta_ready     = '0;
    s.data_stream_tready = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_id == CH_W'(c)) begin
        m.udp_meta_ip_addr   = s.udp_meta_ip_addr[c*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
        m.udp_meta_dst_port  = s.udp_meta_dst_port[c*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
        m.udp_meta_src_port  = s.udp_meta_src_port[c*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
        m.udp_meta_data_len  = s.udp_meta_data_len[c*UDP_LEN_WIDTH +: UDP_LEN_WIDTH];
        m.data_stream_tdata  = s.data_stream_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        m.data_stream_tkeep  = s.data_stream_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
        m.data_stream_tfirst = s.data_stream_tfirst[c];
        m.data_stream_tlast  = s.data_stream_tlast[c];
        if (state == ST_META) begin
          m.udp_meta_valid    = s.udp_meta_valid[c];
          s.udp_meta_ready[c] = m.udp_meta_ready[0];
        end
        if (state == ST_DATA) begin
          m.data_stream_tvalid    = s.data_stream_tvalid[c];
          s.data_stream_tready[c] = m.data_stream_tready[0];
        end
      end
    end
  end

`ifdef UDP_TX_ARB_LEN_CHECK_EN
  logic [UDP_LEN_WIDTH-1:0] byte_cnt;
  logic [UDP_LEN_WIDTH-1:0] len_latched;
  logic [UDP_LEN_WIDTH-1:0] byte_next;
  logic [UDP_LEN_WIDTH:0]   keep_cnt;
  logic [UDP_LEN_WIDTH:0]   sum_ext;

  // One extra bit catches the carry so the count saturates instead of wrapping.
  always_comb begin
    keep_cnt = '0;
    for (int unsigned k = 0; k < KEEP_WIDTH; k++)
      keep_cnt = keep_cnt + (UDP_LEN_WIDTH+1)'(m.data_stream_tkeep[k]);
    sum_ext   = {1'b0, byte_cnt} + keep_cnt;
    byte_next = sum_ext[UDP_LEN_WIDTH] ? '1 : sum_ext[UDP_LEN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt    <= '0;
      len_latched <= '0;
      len_err     <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (state == ST_META && meta_hs) begin
        byte_cnt    <= '0;
        len_latched <= m.udp_meta_data_len;
      end else if (state == ST_DATA && data_hs) begin
        byte_cnt <= byte_next;
        if (m.data_stream_tlast[0]) len_err <= (byte_next != len_latched);
      end
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_stream_arbiter.sv
module tb_udp_tx_stream_arbiter;
  import udp_tx_arb_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 256;
  localparam int KW     = 32;
  localparam int IPW    = 32;
  localparam int PW     = 16;
  localparam int LW     = 16;
`ifdef UDP_TX_ARB_LEN_CHECK_EN
  localparam bit LEN_ON = 1'b1;
`else
  localparam bit LEN_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          first;
    logic          last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       len_err;

  always #5 clk = ~clk;

  udp_tx_stream_arbiter_if #(.N(NUM_CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .IP_ADDR_WIDTH(IPW), .UDP_PORT_WIDTH(PW), .UDP_LEN_WIDTH(LW)) s_if ();
  udp_tx_stream_arbiter_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .IP_ADDR_WIDTH(IPW), .UDP_PORT_WIDTH(PW), .UDP_LEN_WIDTH(LW)) m_if ();

  udp_tx_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .IP_ADDR_WIDTH(IPW), .UDP_PORT_WIDTH(PW), .UDP_LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s           (s_if),
    .m           (m_if),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .len_err     (len_err)
  );

  // Scoreboard
  udp_meta_t exp_meta [NUM_CH][$];
  beat_t     exp_beat [NUM_CH][$];
  logic      exp_err  [NUM_CH][$];
  int        exp_grant[$];
  int        total = 0;
  int        bad   = 0;
  int        beats_seen = 0;
  logic      meta_open [NUM_CH];
  logic      len_pend = 1'b0;
  logic      len_exp  = 1'b0;
  logic      abort = 1'b0;
  logic      rand_tready = 1'b0;
  logic      tready_force = 1'b0;

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void fail_empty(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=unexpected-transfer required=none", nm);
  endfunction

  function automatic udp_meta_t mk_meta(input logic [15:0] len, input logic [31:0] ip,
                                        input logic [15:0] dp, input logic [15:0] sp);
    udp_meta_t md;
    md.data_len = len;
    md.ip_addr  = ip;
    md.dst_port = dp;
    md.src_port = sp;
    return md;
  endfunction

  // Requester model: pushes expectations, then drives meta and beats with
  // AXI-S hold-until-handshake behaviour. Handshakes are judged at negedge.
  task automatic send_pkt(input int ch, input udp_meta_t md, input int nbeats,
                          input logic [31:0] seed, input logic [KW-1:0] keep_last,
                          input bit early, input bit exp_len_err);
    beat_t bq[$];
    beat_t b;
    int    cyc;
    bit    stop;
    exp_meta[ch].push_back(md);
    for (int k = 0; k < nbeats; k++) begin
      b.data  = {8{seed + 32'(k)}};
      b.keep  = (k == nbeats - 1) ? keep_last : '1;
      b.first = (k == 0);
      b.last  = (k == nbeats - 1);
      bq.push_back(b);
      exp_beat[ch].push_back(b);
    end
    exp_err[ch].push_back(LEN_ON & exp_len_err);

    s_if.udp_meta_valid[ch]               = 1'b1;
    s_if.udp_meta_ip_addr[ch*IPW +: IPW]  = md.ip_addr;
    s_if.udp_meta_dst_port[ch*PW +: PW]   = md.dst_port;
    s_if.udp_meta_src_port[ch*PW +: PW]   = md.src_port;
    s_if.udp_meta_data_len[ch*LW +: LW]   = md.data_len;
    if (early) begin
      s_if.data_stream_tvalid[ch]         = 1'b1;
      s_if.data_stream_tdata[ch*DW +: DW] = bq[0].data;
      s_if.data_stream_tkeep[ch*KW +: KW] = bq[0].keep;
      s_if.data_stream_tfirst[ch]         = bq[0].first;
      s_if.data_stream_tlast[ch]          = bq[0].last;
    end
    stop = 1'b0;
    cyc  = 0;
    forever begin
      @(negedge clk);
      if (abort) begin stop = 1'b1; break; end
      if (s_if.udp_meta_ready[ch]) break;
      if (++cyc > 300) begin chk("meta_timeout", 0, 1); stop = 1'b1; break; end
    end
    if (!stop) begin
      @(posedge clk); #1;
      s_if.udp_meta_valid[ch] = 1'b0;
      for (int k = 0; k < nbeats && !stop; k++) begin
        s_if.data_stream_tvalid[ch]         = 1'b1;
        s_if.data_stream_tdata[ch*DW +: DW] = bq[k].data;
        s_if.data_stream_tkeep[ch*KW +: KW] = bq[k].keep;
        s_if.data_stream_tfirst[ch]         = bq[k].first;
        s_if.data_stream_tlast[ch]          = bq[k].last;
        cyc = 0;
        forever begin
          @(negedge clk);
          if (abort) begin stop = 1'b1; break; end
          if (s_if.data_stream_tready[ch]) break;
          if (++cyc > 300) begin chk("beat_timeout", 0, 1); stop = 1'b1; break; end
        end
        if (!stop) begin @(posedge clk); #1; end
      end
    end
    s_if.udp_meta_valid[ch]     = 1'b0;
    s_if.data_stream_tvalid[ch] = 1'b0;
  endtask

  // Core-side tready
  initial begin
    m_if.data_stream_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_if.data_stream_tready = rand_tready ? 1'($urandom_range(0, 1)) : tready_force;
    end
  end

  // Monitor
  initial begin
    beat_t     eb;
    udp_meta_t em;
    int        g;
    for (int c = 0; c < NUM_CH; c++) meta_open[c] = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int c = 0; c < NUM_CH; c++) meta_open[c] = 1'b0;
        len_pend = 1'b0;
      end
      chk("len_err", len_err, len_pend ? len_exp : 1'b0);
      len_pend = 1'b0;
      if (m_if.udp_meta_valid[0] || m_if.data_stream_tvalid[0])
        chk("valid_exclusive", m_if.udp_meta_valid[0] & m_if.data_stream_tvalid[0], 0);
      for (int c = 0; c < NUM_CH; c++)
        if (s_if.data_stream_tvalid[c] && !meta_open[c])
          chk("tready_before_meta", s_if.data_stream_tready[c], 0);
      g = int'(grant_id);
      if (m_if.udp_meta_valid[0] && m_if.udp_meta_ready[0]) begin
        if (exp_grant.size() == 0) fail_empty("grant_order");
        else chk("grant_order", g, exp_grant.pop_front());
        if (exp_meta[g].size() == 0) fail_empty("meta");
        else begin
          em = exp_meta[g].pop_front();
          chk("meta_data_len", m_if.udp_meta_data_len, em.data_len);
          chk("meta_ip_addr",  m_if.udp_meta_ip_addr,  em.ip_addr);
          chk("meta_dst_port", m_if.udp_meta_dst_port, em.dst_port);
          chk("meta_src_port", m_if.udp_meta_src_port, em.src_port);
        end
        meta_open[g] = 1'b1;
      end
      if (m_if.data_stream_tvalid[0] && m_if.data_stream_tready[0]) begin
        chk("grant_stable", meta_open[g], 1);
        if (exp_beat[g].size() == 0) fail_empty("beat");
        else begin
          eb = exp_beat[g].pop_front();
          chk("beat_data",  m_if.data_stream_tdata,  eb.data);
          chk("beat_keep",  m_if.data_stream_tkeep,  eb.keep);
          chk("beat_first", m_if.data_stream_tfirst, eb.first);
          chk("beat_last",  m_if.data_stream_tlast,  eb.last);
        end
        beats_seen++;
        if (m_if.data_stream_tlast[0]) begin
          meta_open[g] = 1'b0;
          len_pend = 1'b1;
          if (exp_err[g].size() != 0) len_exp = exp_err[g].pop_front();
          else len_exp = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=no-finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int cyc;
    s_if.udp_meta_valid     = '0;
    s_if.udp_meta_ip_addr   = '0;
    s_if.udp_meta_dst_port  = '0;
    s_if.udp_meta_src_port  = '0;
    s_if.udp_meta_data_len  = '0;
    s_if.data_stream_tvalid = '0;
    s_if.data_stream_tdata  = '0;
    s_if.data_stream_tkeep  = '0;
    s_if.data_stream_tfirst = '0;
    s_if.data_stream_tlast  = '0;
    m_if.udp_meta_ready     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_meta_valid", m_if.udp_meta_valid, 0);
    chk("rst_tvalid", m_if.data_stream_tvalid, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_s_ready", {s_if.udp_meta_ready, s_if.data_stream_tready}, 0);
    @(negedge clk) reset_n = 1'b1;
    m_if.udp_meta_ready = 1'b1;
    tready_force = 1'b1;

    // 1: ch2 len 64, two full beats; grant one cycle after request
    exp_grant.push_back(2);
    @(posedge clk); #1;
    fork
      send_pkt(2, mk_meta(16'd64, 32'hC0A8_0102, 16'd5000, 16'd6000), 2, 32'h1000_0000, '1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        chk("t1_no_grant_yet", grant_valid, 0);
        @(negedge clk);
        chk("t1_grant_valid", grant_valid, 1);
        chk("t1_grant_id", grant_id, 2);
        chk("t1_meta_valid", m_if.udp_meta_valid, 1);
      end
    join
    @(negedge clk);
    chk("t1_idle_after_tlast", grant_valid, 0);

    // 2: all four from reset, ch0 twice -> 0,1,2,3,0
    pulse_reset();
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    @(posedge clk); #1;
    fork
      begin
        send_pkt(0, mk_meta(16'd32, 32'h0A00_0000, 16'd100, 16'd200), 1, 32'h2000_0000, '1, 1'b0, 1'b0);
        send_pkt(0, mk_meta(16'd32, 32'h0A00_0004, 16'd104, 16'd204), 1, 32'h2400_0000, '1, 1'b0, 1'b0);
      end
      send_pkt(1, mk_meta(16'd32, 32'h0A00_0001, 16'd101, 16'd201), 1, 32'h2100_0000, '1, 1'b0, 1'b0);
      send_pkt(2, mk_meta(16'd32, 32'h0A00_0002, 16'd102, 16'd202), 1, 32'h2200_0000, '1, 1'b0, 1'b0);
      send_pkt(3, mk_meta(16'd32, 32'h0A00_0003, 16'd103, 16'd203), 1, 32'h2300_0000, '1, 1'b0, 1'b0);
    join

    // 3: ch3 8 beats under random tready, last beat 16 bytes -> 240
    exp_grant.push_back(3);
    @(posedge clk); #1;
    rand_tready = 1'b1;
    send_pkt(3, mk_meta(16'd240, 32'h0B00_0003, 16'd300, 16'd400), 8, 32'h3000_0000, 32'h0000_FFFF, 1'b0, 1'b0);
    rand_tready = 1'b0;

    // 4: ch1 presents data early while ch0 owns the core
    exp_grant.push_back(0); exp_grant.push_back(1);
    @(posedge clk); #1;
    tready_force = 1'b0;
    fork
      send_pkt(0, mk_meta(16'd128, 32'h0C00_0000, 16'd500, 16'd600), 4, 32'h4000_0000, '1, 1'b0, 1'b0);
      send_pkt(1, mk_meta(16'd64, 32'h0C00_0001, 16'd501, 16'd601), 2, 32'h4100_0000, '1, 1'b1, 1'b0);
      begin
        repeat (4) @(negedge clk);
        chk("t4_owner", grant_id, 0);
        chk("t4_ch1_blocked", s_if.data_stream_tready[1], 0);
        repeat (4) @(posedge clk);
        tready_force = 1'b1;
      end
    join

    // 5: reset during beat 3 of 6, then re-arbitration from rr_ptr=3
    exp_grant.push_back(2);
    base = beats_seen;
    @(posedge clk); #1;
    fork
      send_pkt(2, mk_meta(16'd192, 32'h0D00_0002, 16'd700, 16'd800), 6, 32'h5000_0000, '1, 1'b0, 1'b0);
      begin
        cyc = 0;
        while (beats_seen < base + 3 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("t5_reach_beat3", beats_seen, base + 3);
        @(posedge clk); #2;
        reset_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("t5_meta_valid_drop", m_if.udp_meta_valid, 0);
        chk("t5_tvalid_drop", m_if.data_stream_tvalid, 0);
        chk("t5_grant_valid_drop", grant_valid, 0);
        chk("t5_s_ready_drop", {s_if.udp_meta_ready, s_if.data_stream_tready}, 0);
      end
    join
    repeat (2) @(posedge clk);
    exp_beat[2].delete();
    exp_err[2].delete();
    exp_meta[2].delete();
    abort = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    chk("t5_rst_grant_id", grant_id, 0);
    exp_grant.push_back(1); exp_grant.push_back(3);
    @(posedge clk); #1;
    fork
      send_pkt(3, mk_meta(16'd32, 32'h0D00_0003, 16'd703, 16'd803), 1, 32'h5300_0000, '1, 1'b0, 1'b0);
      send_pkt(1, mk_meta(16'd32, 32'h0D00_0001, 16'd701, 16'd801), 1, 32'h5100_0000, '1, 1'b0, 1'b0);
    join

    // 6: length check, 3 full beats = 96 bytes vs len 100 then len 96
    exp_grant.push_back(1); exp_grant.push_back(1);
    send_pkt(1, mk_meta(16'd100, 32'h0E00_0001, 16'd900, 16'd901), 3, 32'h6000_0000, '1, 1'b0, 1'b1);
    send_pkt(1, mk_meta(16'd96,  32'h0E00_0002, 16'd902, 16'd903), 3, 32'h6100_0000, '1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    for (int c = 0; c < NUM_CH; c++) begin
      chk("leftover_beats", exp_beat[c].size(), 0);
      chk("leftover_meta", exp_meta[c].size(), 0);
    end
    chk("leftover_grants", exp_grant.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
